// File: rtl/sensor_telemetry_framer_pkg.sv
// Shared types and helpers for the telemetry framer.
// Frame layout: sync, header, channel bytes, xor checksum.
package sensor_telemetry_framer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_HDR,
    ST_DATA,
    ST_CHK
  } frame_state_t;

  typedef struct packed {
    logic       ovr;
    logic [6:0] seq;
  } frame_hdr_t;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

  function automatic int calc_bpc(input int data_w);
    return (data_w + 7) / 8;
  endfunction

  function automatic int calc_clks_per_bit(
    input int clk_hz,
    input int baud
  );
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sensor_telemetry_framer_uart_tx_byte.sv
// 8N1 byte transmitter, LSB first, idle high.
// A new load is taken in the last stop-bit clock so bytes run back-to-back.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       load,
  output logic       tx,
  output logic       done,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt;
  logic [3:0]    bit_n;
  logic [8:0]    shreg;
  logic          active;
  logic          bit_end;

  assign bit_end = (cnt == CW'(CLKS_PER_BIT - 1));
  assign done    = active && bit_end && (bit_n == 4'd9);
  assign busy    = active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      cnt    <= '0;
      bit_n  <= '0;
      shreg  <= '1;
      tx     <= 1'b1;
    end else if (load && (!active || done)) begin
      active <= 1'b1;
      cnt    <= '0;
      bit_n  <= '0;
      shreg  <= {1'b1, data};
      tx     <= 1'b0;
    end else if (active) begin
      if (bit_end) begin
        cnt <= '0;
        if (bit_n == 4'd9) begin
          active <= 1'b0;
        end else begin
          // shreg fills with ones so bit 8 shifts out as the stop bit
          tx    <= shreg[0];
          shreg <= {1'b1, shreg[8:1]};
          bit_n <= bit_n + 4'd1;
        end
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sensor_telemetry_framer.sv
// Snapshots NUM_CH channels and sends them as one framed UART packet.
// Frame: SYNC, {overrun,seq}, channel bytes (ch0 first, MSB byte first), XOR checksum.
module sensor_telemetry_framer
  import sensor_telemetry_framer_pkg::*;
#(
  parameter int         NUM_CH      = 4,
  parameter int         DATA_W      = 8,
  parameter int         CLK_FREQ_HZ = 100000000,
  parameter int         BAUD        = 230400,
  parameter logic [7:0] SYNC_BYTE   = DEF_SYNC_BYTE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic                     capture,
  input  logic                     start,
  input  logic                     continuous,
  output logic                     tx,
  output logic                     ready,
  output logic                     busy,
  output logic                     overrun
);

  localparam int BPC    = calc_bpc(DATA_W);
  localparam int PW     = BPC * 8;
  localparam int NBYTES = NUM_CH * BPC;
  localparam int CPB    = calc_clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  function automatic logic [NBYTES*8-1:0] pack_frame(
    input logic [NUM_CH*DATA_W-1:0] d
  );
    logic [PW-1:0] ch;
    pack_frame = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ch = '0;
      ch[DATA_W-1:0] = d[c*DATA_W +: DATA_W];
      for (int b = 0; b < BPC; b++) begin
        pack_frame[(c*BPC+b)*8 +: 8] = ch[(BPC-1-b)*8 +: 8];
      end
    end
  endfunction

  frame_state_t             state;
  frame_hdr_t               hdr;
  logic [NUM_CH*DATA_W-1:0] shadow;
  logic [NBYTES*8-1:0]      fbuf;
  logic [6:0]               seq;
  logic [7:0]               chk;
  logic [IW-1:0]            idx;
  logic                     fresh;
  logic                     chk_sent;

  logic       u_load;
  logic [7:0] u_byte;
  logic       u_done;
  logic       u_busy;
  logic       u_free;
  logic       cap_lost;
  logic       go;
  logic [7:0] data_byte;

  assign busy      = ~ready;
  assign cap_lost  = capture && fresh;
  assign go        = (state == ST_IDLE) &&
                     (start || (continuous && fresh));
  assign u_free    = !u_busy || u_done;
  assign data_byte = fbuf[{idx, 3'b000} +: 8];

  always_comb begin
    u_load = 1'b0;
    u_byte = SYNC_BYTE;
    unique case (1'b1)
      state == ST_SYNC: begin
        u_load = u_free;
        u_byte = SYNC_BYTE;
      end
      state == ST_HDR: begin
        u_load = u_free;
        u_byte = hdr;
      end
      state == ST_DATA: begin
        u_load = u_free;
        u_byte = data_byte;
      end
      state == ST_CHK: begin
        u_load = u_free && !chk_sent;
        u_byte = chk;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      hdr      <= '0;
      shadow   <= '0;
      fbuf     <= '0;
      seq      <= '0;
      chk      <= '0;
      idx      <= '0;
      fresh    <= 1'b0;
      chk_sent <= 1'b0;
      overrun  <= 1'b0;
      ready    <= 1'b1;
    end else begin
      if (capture) begin
        shadow <= ch_data;
        fresh  <= 1'b1;
      end
      if (cap_lost) overrun <= 1'b1;

      unique case (state)
        ST_IDLE: begin
          if (go) begin
            // a capture in the same cycle goes straight into this frame
            fbuf     <= pack_frame(capture ? ch_data : shadow);
            fresh    <= 1'b0;
            hdr      <= '{ovr: overrun, seq: seq};
            overrun  <= cap_lost;
            seq      <= seq + 7'd1;
            chk      <= '0;
            idx      <= '0;
            chk_sent <= 1'b0;
            ready    <= 1'b0;
            state    <= ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (u_load) state <= ST_HDR;
        end
        ST_HDR: begin
          if (u_load) begin
            chk   <= hdr;
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (u_load) begin
            chk <= chk ^ data_byte;
            if (idx == IW'(NBYTES - 1)) state <= ST_CHK;
            else idx <= idx + IW'(1);
          end
        end
        ST_CHK: begin
          if (u_load) begin
            chk_sent <= 1'b1;
          end else if (chk_sent && u_done) begin
            ready <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CPB)
  ) u_uart (
    .clk (clk),
    .rst (rst),
    .data(u_byte),
    .load(u_load),
    .tx  (tx),
    .done(u_done),
    .busy(u_busy)
  );

endmodule

// File: tb/tb_sensor_telemetry_framer.sv
// Directed bench: two framer configs at 4 clocks per bit, tx decoded on negedges.
module tb_sensor_telemetry_framer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] ch_a;
  logic        cap_a, start_a, cont_a;
  logic        tx_a, ready_a, busy_a, ovr_a;
  logic [11:0] ch_b;
  logic        cap_b, start_b, cont_b;
  logic        tx_b, ready_b, busy_b, ovr_b;

  sensor_telemetry_framer #(
    .NUM_CH(2), .DATA_W(8),
    .CLK_FREQ_HZ(1000000), .BAUD(250000)
  ) u_a (
    .clk(clk), .rst(rst), .ch_data(ch_a),
    .capture(cap_a), .start(start_a),
    .continuous(cont_a), .tx(tx_a),
    .ready(ready_a), .busy(busy_a),
    .overrun(ovr_a)
  );

  sensor_telemetry_framer #(
    .NUM_CH(1), .DATA_W(12),
    .CLK_FREQ_HZ(1000000), .BAUD(250000)
  ) u_b (
    .clk(clk), .rst(rst), .ch_data(ch_b),
    .capture(cap_b), .start(start_b),
    .continuous(cont_b), .tx(tx_b),
    .ready(ready_b), .busy(busy_b),
    .overrun(ovr_b)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   low_a = 0;
  logic sel_b;
  logic line;
  logic rdy;

  assign line = sel_b ? tx_b : tx_a;
  assign rdy  = sel_b ? ready_b : ready_a;

  always @(negedge clk) if (ready_a === 1'b0) low_a = low_a + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rx_byte(input string tag, output logic [7:0] b);
    int t = 0;
    b = 'x;
    while (line !== 1'b0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (line !== 1'b0) begin
      chk({tag, "_start"}, {31'b0, line}, 32'd0);
      return;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (4) @(negedge clk);
      b[i] = line;
    end
    repeat (4) @(negedge clk);
    chk({tag, "_stop"}, {31'b0, line}, 32'd1);
  endtask

  task automatic rx_frame(input string tag, input logic [39:0] exp);
    logic [7:0] b;
    for (int k = 0; k < 5; k++) begin
      rx_byte($sformatf("%s_b%0d", tag, k), b);
      chk($sformatf("%s_b%0d", tag, k), {24'b0, b},
          {24'b0, exp[39-8*k -: 8]});
    end
  endtask

  task automatic wait_ready(input string tag);
    int t = 0;
    while (rdy !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_ready"}, {31'b0, rdy}, 32'd1);
  endtask

  initial begin
    int l0;
    logic [7:0] i8, hs;
    rst = 1'b1;
    sel_b = 1'b0;
    ch_a = '0; cap_a = 0; start_a = 0; cont_a = 0;
    ch_b = '0; cap_b = 0; start_b = 0; cont_b = 0;
    repeat (2) @(negedge clk);
    chk("rst_tx_a", {31'b0, tx_a}, 1);
    chk("rst_ready_a", {31'b0, ready_a}, 1);
    chk("rst_busy_a", {31'b0, busy_a}, 0);
    chk("rst_ovr_a", {31'b0, ovr_a}, 0);
    chk("rst_tx_b", {31'b0, tx_b}, 1);
    chk("rst_ready_b", {31'b0, ready_b}, 1);
    chk("rst_busy_b", {31'b0, busy_b}, 0);
    chk("rst_ovr_b", {31'b0, ovr_b}, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: capture then start
    ch_a = 16'h1234;
    cap_a = 1;
    @(negedge clk);
    cap_a = 0;
    start_a = 1;
    l0 = low_a;
    @(negedge clk);
    start_a = 0;
    chk("t1_busy", {31'b0, busy_a}, 1);
    rx_frame("t1", 40'hA5_00_34_12_26);
    wait_ready("t1");
    chk("t1_low_cycles", low_a - l0, 201);

    // 2: 12-bit channel, capture and start together
    sel_b = 1;
    ch_b = 12'hABC;
    cap_b = 1;
    start_b = 1;
    @(negedge clk);
    cap_b = 0;
    start_b = 0;
    rx_frame("t2", 40'hA5_00_0A_BC_B6);
    wait_ready("t2");
    sel_b = 0;

    // 3: two captures before a frame
    ch_a = 16'h5678;
    cap_a = 1;
    @(negedge clk);
    ch_a = 16'h9ABC;
    @(negedge clk);
    cap_a = 0;
    chk("t3_ovr_set", {31'b0, ovr_a}, 1);
    start_a = 1;
    @(negedge clk);
    start_a = 0;
    chk("t3_ovr_clr", {31'b0, ovr_a}, 0);
    chk("t3_ready", {31'b0, ready_a}, 0);
    rx_frame("t3", 40'hA5_81_BC_9A_A7);
    wait_ready("t3");

    // 5: starts during a frame are dropped; back-to-back start
    start_a = 1;
    fork
      begin
        @(negedge clk);
        start_a = 0;
        repeat (30) @(negedge clk);
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        repeat (80) @(negedge clk);
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        repeat (60) @(negedge clk);
        start_a = 1;
        @(negedge clk);
        start_a = 0;
      end
      rx_frame("t5a", 40'hA5_02_BC_9A_24);
    join
    wait_ready("t5a");
    start_a = 1;
    @(negedge clk);
    start_a = 0;
    chk("t5_lat_hi", {31'b0, tx_a}, 1);
    @(negedge clk);
    chk("t5_lat_lo", {31'b0, tx_a}, 0);
    rx_frame("t5b", 40'hA5_03_BC_9A_25);
    wait_ready("t5b");
    repeat (50) @(negedge clk);
    chk("t5_no_queue", {31'b0, ready_a}, 1);

    // 6: reset during the data bits
    ch_a = 16'h0000;
    cap_a = 1;
    @(negedge clk);
    cap_a = 0;
    start_a = 1;
    @(negedge clk);
    start_a = 0;
    repeat (10) @(negedge clk);
    ch_a = 16'h1122;
    cap_a = 1;
    repeat (2) @(negedge clk);
    cap_a = 0;
    repeat (88) @(negedge clk);
    chk("t6_pre_ovr", {31'b0, ovr_a}, 1);
    chk("t6_pre_tx", {31'b0, tx_a}, 0);
    #2 rst = 1;
    #1;
    chk("t6_rst_tx", {31'b0, tx_a}, 1);
    chk("t6_rst_ready", {31'b0, ready_a}, 1);
    chk("t6_rst_busy", {31'b0, busy_a}, 0);
    chk("t6_rst_ovr", {31'b0, ovr_a}, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    start_a = 1;
    @(negedge clk);
    start_a = 0;
    rx_frame("t6", 40'hA5_00_00_00_00);
    wait_ready("t6");

    // 4: continuous mode, 130 frames across the seq wrap
    cont_a = 1;
    for (int i = 0; i < 130; i++) begin
      i8 = 8'(i);
      hs = 8'((i + 1) % 128);
      ch_a = {i8 ^ 8'h5A, i8};
      cap_a = 1;
      @(negedge clk);
      cap_a = 0;
      rx_frame($sformatf("t4_f%0d", i),
               {8'hA5, hs, i8, i8 ^ 8'h5A, hs ^ 8'h5A});
      repeat (95) @(negedge clk);
    end
    cont_a = 0;
    chk("t4_ovr", {31'b0, ovr_a}, 0);
    chk("t4_ready", {31'b0, ready_a}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
